// File: rtl/xbar_ingress_parser_if.sv
// Ingress-side stream bundle for xbar_ingress_parser: raw beat input and decoded-packet output.
// The slave modport is the parser; the master modport is the upstream source / downstream consumer.
interface xbar_ingress_parser_if #(
  parameter int unsigned PORTS         = 8,
  parameter int unsigned SLOTS         = 4,
  parameter int unsigned PACKET_WIDTH  = 8,
  parameter int unsigned PAYLOAD_BEATS = 1
);
  localparam int unsigned AW = $clog2(PORTS);
  localparam int unsigned SW = $clog2(SLOTS);

  logic                                  in_valid;
  logic                                  in_ready;
  logic [PACKET_WIDTH-1:0]               in_data;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [AW-1:0]                         out_port;
  logic [SW-1:0]                         out_slot;
  logic [PACKET_WIDTH*PAYLOAD_BEATS-1:0] out_data;
  logic                                  out_perr;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_port, out_slot, out_data, out_perr
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_port, out_slot, out_data, out_perr
  );
endinterface

// File: rtl/xbar_ingress_parser.sv
// Per-port ingress parser: checks header/payload parity, decodes port and slot, and queues
// decoded packets in a small FIFO feeding the crossbar arbitration stage.
module xbar_ingress_parser #(
  parameter int unsigned PORTS         = 8,
  parameter int unsigned SLOTS         = 4,
  parameter int unsigned PACKET_WIDTH  = 8,
  parameter int unsigned PAYLOAD_BEATS = 1,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter bit          DROP_PERR     = 1'b0,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  xbar_ingress_parser_if.slave bus,
  output logic [CNT_WIDTH-1:0] hdr_err_cnt_o,
  output logic [CNT_WIDTH-1:0] pay_err_cnt_o,
  output logic                 fifo_full_o
);
  localparam int unsigned W   = PACKET_WIDTH;
  localparam int unsigned AW  = $clog2(PORTS);
  localparam int unsigned SW  = $clog2(SLOTS);
  localparam int unsigned DW  = W * PAYLOAD_BEATS;
  localparam int unsigned BCW = (PAYLOAD_BEATS > 1) ? $clog2(PAYLOAD_BEATS) : 1;
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned HW  = 3 + AW + SW;
  localparam logic [BCW-1:0] LastBeat = BCW'(PAYLOAD_BEATS - 1);

  typedef enum logic [1:0] {StIdle, StPayload, StDiscard} state_e;

  typedef struct packed {
    logic [AW-1:0] port;
    logic [SW-1:0] slot;
    logic [DW-1:0] data;
    logic          perr;
  } entry_t;

  state_e               state_q, state_d;
  logic [BCW-1:0]       beat_cnt_q, beat_cnt_d;
  logic [AW-1:0]        port_q, port_d;
  logic [SW-1:0]        slot_q, slot_d;
  logic                 par_q, par_d;
  logic [DW-1:0]        data_q, data_d;
  logic [CNT_WIDTH-1:0] hdr_cnt_q, pay_cnt_q;

  entry_t               mem_q [FIFO_DEPTH];
  entry_t               wr_entry, head;
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PW:0]          count_q, count_d;

  logic [W-1:0]  beat;
  logic [AW-1:0] hdr_addr;
  logic [SW-1:0] hdr_slot;
  logic          hdr_pp, hdr_ok, beat_par;
  logic          in_ready, accept, last_beat, full, empty, push, pop;
  logic          push_perr, hdr_err_inc, pay_err_inc;

  assign beat      = bus.in_data;
  assign hdr_addr  = beat[W-2 -: AW];
  assign hdr_slot  = beat[W-2-AW -: SW];
  assign hdr_pp    = beat[W-2-AW-SW];
  // Even parity over valid..hp; reserved LSBs below hp are excluded.
  assign hdr_ok    = ~^beat[W-1 -: HW] && (32'(hdr_addr) < PORTS);
  assign beat_par  = par_q ^ (^beat);

  assign full      = (count_q == (PW+1)'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign last_beat = (beat_cnt_q == LastBeat);
  // Depends only on registered state, so out_ready never reaches in_ready combinationally.
  assign in_ready  = !rst && !(state_q == StPayload && last_beat && full);
  assign accept    = bus.in_valid && in_ready;
  assign pop       = !empty && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    port_d      = port_q;
    slot_d      = slot_q;
    par_d       = par_q;
    data_d      = data_q;
    push        = 1'b0;
    push_perr   = 1'b0;
    hdr_err_inc = 1'b0;
    pay_err_inc = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept && beat[W-1]) begin
          beat_cnt_d = '0;
          if (hdr_ok) begin
            port_d  = hdr_addr;
            slot_d  = hdr_slot;
            par_d   = hdr_pp;
            state_d = StPayload;
          end else begin
            hdr_err_inc = 1'b1;
            state_d     = StDiscard;
          end
        end
      end
      StPayload: begin
        if (accept) begin
          data_d[32'(beat_cnt_q) * W +: W] = beat;
          par_d = beat_par;
          if (last_beat) begin
            state_d     = StIdle;
            pay_err_inc = beat_par;
            push_perr   = beat_par;
            push        = !(beat_par && DROP_PERR);
          end else begin
            beat_cnt_d = beat_cnt_q + BCW'(1);
          end
        end
      end
      StDiscard: begin
        if (accept) begin
          if (last_beat) state_d = StIdle;
          else           beat_cnt_d = beat_cnt_q + BCW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_entry = '{port: port_q, slot: slot_q, data: data_d, perr: push_perr};
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      beat_cnt_q <= '0;
      port_q     <= '0;
      slot_q     <= '0;
      par_q      <= 1'b0;
      data_q     <= '0;
      hdr_cnt_q  <= '0;
      pay_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      port_q     <= port_d;
      slot_q     <= slot_d;
      par_q      <= par_d;
      data_q     <= data_d;
      count_q    <= count_d;
      if (hdr_err_inc && hdr_cnt_q != '1) hdr_cnt_q <= hdr_cnt_q + CNT_WIDTH'(1);
      if (pay_err_inc && pay_cnt_q != '1) pay_cnt_q <= pay_cnt_q + CNT_WIDTH'(1);
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Head is forced to zero when empty so the outputs read 0 out of reset.
  assign head          = mem_q[rd_ptr_q];
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = !empty;
  assign bus.out_port  = empty ? '0 : head.port;
  assign bus.out_slot  = empty ? '0 : head.slot;
  assign bus.out_data  = empty ? '0 : head.data;
  assign bus.out_perr  = empty ? 1'b0 : head.perr;
  assign hdr_err_cnt_o = hdr_cnt_q;
  assign pay_err_cnt_o = pay_cnt_q;
  assign fifo_full_o   = full;
endmodule

// File: tb/tb_xbar_ingress_parser.sv
// Bench for xbar_ingress_parser: three configurations driven from directed and random packet
// streams, checked every cycle against a packet-level reference model.
module tb_xbar_ingress_parser;
  localparam int NI    = 3;
  localparam int Depth = 4;

  typedef struct {
    logic [2:0]  port;
    logic [1:0]  slot;
    logic [15:0] data;
    logic        perr;
  } pkt_t;

  typedef struct {
    logic        rdy, vld, full, perr;
    logic [31:0] port, slot, data, hcnt, pcnt;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned pb_cfg   [NI] = '{1, 1, 2};
  bit          drop_cfg [NI] = '{1'b0, 1'b1, 1'b0};
  int unsigned cmax_cfg [NI] = '{65535, 7, 65535};

  xbar_ingress_parser_if #(.PAYLOAD_BEATS(1)) bus0 ();
  xbar_ingress_parser_if #(.PAYLOAD_BEATS(1)) bus1 ();
  xbar_ingress_parser_if #(.PAYLOAD_BEATS(2)) bus2 ();

  logic [15:0] hcnt0, pcnt0, hcnt2, pcnt2;
  logic [2:0]  hcnt1, pcnt1;
  logic        full0, full1, full2;

  xbar_ingress_parser #(.PAYLOAD_BEATS(1), .DROP_PERR(1'b0), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave),
    .hdr_err_cnt_o(hcnt0), .pay_err_cnt_o(pcnt0), .fifo_full_o(full0)
  );
  xbar_ingress_parser #(.PAYLOAD_BEATS(1), .DROP_PERR(1'b1), .CNT_WIDTH(3)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave),
    .hdr_err_cnt_o(hcnt1), .pay_err_cnt_o(pcnt1), .fifo_full_o(full1)
  );
  xbar_ingress_parser #(.PAYLOAD_BEATS(2), .DROP_PERR(1'b0), .CNT_WIDTH(16)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave),
    .hdr_err_cnt_o(hcnt2), .pay_err_cnt_o(pcnt2), .fifo_full_o(full2)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  pkt_t        exp_q [$];
  logic [7:0]  dir_q [$];
  logic [7:0]  cur_q [$];
  int          cur_len;
  bit          use_dir, cur_pkt, cur_hok;
  pkt_t        cur_info;
  int unsigned hdr_cnt, pay_cnt;

  task automatic check_eq(input string tag, input longint unsigned obs,
                          input longint unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned sat_inc(input int unsigned c, input int unsigned m);
    return (c >= m) ? m : c + 1;
  endfunction

  task automatic drive(input int k, input logic v, input logic [7:0] d, input logic r);
    case (k)
      0:       begin bus0.in_valid = v; bus0.in_data = d; bus0.out_ready = r; end
      1:       begin bus1.in_valid = v; bus1.in_data = d; bus1.out_ready = r; end
      default: begin bus2.in_valid = v; bus2.in_data = d; bus2.out_ready = r; end
    endcase
  endtask

  task automatic sample(input int k, output obs_t o);
    case (k)
      0: begin
        o.rdy = bus0.in_ready; o.vld = bus0.out_valid; o.full = full0; o.perr = bus0.out_perr;
        o.port = 32'(bus0.out_port); o.slot = 32'(bus0.out_slot);
        o.data = 32'(bus0.out_data); o.hcnt = 32'(hcnt0); o.pcnt = 32'(pcnt0);
      end
      1: begin
        o.rdy = bus1.in_ready; o.vld = bus1.out_valid; o.full = full1; o.perr = bus1.out_perr;
        o.port = 32'(bus1.out_port); o.slot = 32'(bus1.out_slot);
        o.data = 32'(bus1.out_data); o.hcnt = 32'(hcnt1); o.pcnt = 32'(pcnt1);
      end
      default: begin
        o.rdy = bus2.in_ready; o.vld = bus2.out_valid; o.full = full2; o.perr = bus2.out_perr;
        o.port = 32'(bus2.out_port); o.slot = 32'(bus2.out_slot);
        o.data = 32'(bus2.out_data); o.hcnt = 32'(hcnt2); o.pcnt = 32'(pcnt2);
      end
    endcase
  endtask

  // Builds the next stream item (idle word, or header plus payload) and its expected outcome.
  task automatic load_item(input int k);
    logic [7:0] h;
    logic [7:0] p [2];
    logic       x;
    int         n = int'(pb_cfg[k]);
    cur_pkt = 1'b0;
    p[0] = 8'h00;
    p[1] = 8'h00;
    if (use_dir) begin
      if (dir_q.size() == 0) return;
      h = dir_q.pop_front();
      if (h[7]) for (int i = 0; i < n; i++) p[i] = (dir_q.size() != 0) ? dir_q.pop_front() : 8'h00;
    end else if ($urandom_range(0, 4) == 0) begin
      h = {1'b0, 7'($urandom)};
    end else begin
      for (int i = 0; i < n; i++) p[i] = 8'($urandom);
      x = ^p[0] ^ ((n > 1) ? ^p[1] : 1'b0);
      h = {1'b1, 3'($urandom), 2'($urandom), x ^ ($urandom_range(0, 4) == 0), 1'b0};
      h[0] = (^h[7:1]) ^ ($urandom_range(0, 6) == 0);
    end
    cur_q.delete();
    cur_q.push_back(h);
    if (h[7]) begin
      cur_pkt       = 1'b1;
      cur_hok       = (^h == 1'b0) && (int'(h[6:4]) < 8);
      cur_info.port = h[6:4];
      cur_info.slot = h[3:2];
      cur_info.data = '0;
      x = h[1];
      for (int i = 0; i < n; i++) begin
        cur_q.push_back(p[i]);
        x = x ^ (^p[i]);
        cur_info.data = cur_info.data | (16'(p[i]) << (8 * i));
      end
      cur_info.perr = x;
    end
    cur_len = cur_q.size();
  endtask

  task automatic step(input int k, input int vpct, input int rpct);
    obs_t       o;
    logic       exp_rdy, v, r;
    logic [7:0] d;
    @(negedge clk);
    if (cur_q.size() == 0) load_item(k);
    exp_rdy = !(cur_pkt && cur_hok && cur_q.size() == 1 && exp_q.size() == Depth);
    sample(k, o);
    check_eq("in_ready", o.rdy, exp_rdy);
    check_eq("out_valid", o.vld, exp_q.size() != 0);
    check_eq("fifo_full", o.full, exp_q.size() == Depth);
    check_eq("hdr_err_cnt", o.hcnt, hdr_cnt);
    check_eq("pay_err_cnt", o.pcnt, pay_cnt);
    if (exp_q.size() != 0) begin
      check_eq("out_port", o.port, exp_q[0].port);
      check_eq("out_slot", o.slot, exp_q[0].slot);
      check_eq("out_data", o.data, exp_q[0].data);
      check_eq("out_perr", o.perr, exp_q[0].perr);
    end
    v = (cur_q.size() != 0) && ($urandom_range(0, 99) < vpct);
    d = v ? cur_q[0] : 8'($urandom);
    r = $urandom_range(0, 99) < rpct;
    drive(k, v, d, r);
    if (r && exp_q.size() != 0) void'(exp_q.pop_front());
    if (v && exp_rdy) begin
      if (cur_pkt && cur_q.size() == cur_len && !cur_hok)
        hdr_cnt = sat_inc(hdr_cnt, cmax_cfg[k]);
      if (cur_pkt && cur_hok && cur_q.size() == 1) begin
        if (cur_info.perr) pay_cnt = sat_inc(pay_cnt, cmax_cfg[k]);
        if (!(cur_info.perr && drop_cfg[k])) exp_q.push_back(cur_info);
      end
      void'(cur_q.pop_front());
    end
  endtask

  task automatic run(input int k, input int ncyc, input int vpct, input int rpct);
    for (int i = 0; i < ncyc; i++) step(k, vpct, rpct);
  endtask

  task automatic do_reset(input int k);
    obs_t o;
    @(negedge clk);
    rst = 1'b1;
    drive(k, 1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      sample(k, o);
      check_eq("rst in_ready", o.rdy, 0);
      check_eq("rst out_valid", o.vld, 0);
      check_eq("rst fifo_full", o.full, 0);
      check_eq("rst out_port", o.port, 0);
      check_eq("rst out_slot", o.slot, 0);
      check_eq("rst out_data", o.data, 0);
      check_eq("rst out_perr", o.perr, 0);
      check_eq("rst hdr_cnt", o.hcnt, 0);
      check_eq("rst pay_cnt", o.pcnt, 0);
    end
    rst = 1'b0;
    drive(k, 1'b0, 8'h00, 1'b0);
    exp_q.delete();
    cur_q.delete();
    cur_pkt = 1'b0;
    hdr_cnt = 0;
    pay_cnt = 0;
  endtask

  function automatic void add_dir(input logic [7:0] b);
    dir_q.push_back(b);
  endfunction

  initial begin
    for (int k = 0; k < NI; k++) drive(k, 1'b0, 8'h00, 1'b0);

    // Default configuration: directed cases
    do_reset(0);
    use_dir = 1'b1;
    add_dir(8'hB8); add_dir(8'hA5);
    run(0, 5, 100, 0);
    add_dir(8'hB9); add_dir(8'hA5); add_dir(8'hB8); add_dir(8'h0F);
    run(0, 6, 100, 0);
    add_dir(8'hB8); add_dir(8'hA4);
    run(0, 4, 100, 0);
    run(0, 6, 0, 100);
    for (int i = 1; i <= 5; i++) begin
      add_dir(8'hB8);
      add_dir(8'(i * 8'h11));
    end
    run(0, 16, 100, 0);
    run(0, 1, 100, 100);
    run(0, 6, 100, 0);
    run(0, 10, 100, 100);
    use_dir = 1'b0;
    run(0, 400, 70, 50);
    run(0, 100, 90, 20);
    // Reset right after a header is accepted, then a lone payload-like beat
    use_dir = 1'b1;
    run(0, 4, 0, 100);
    add_dir(8'hB8);
    run(0, 1, 100, 0);
    do_reset(0);
    add_dir(8'h5A);
    run(0, 5, 100, 100);

    // Drop-on-payload-error with narrow saturating counters
    do_reset(1);
    use_dir = 1'b1;
    add_dir(8'hB8); add_dir(8'hA4);
    run(1, 5, 100, 100);
    use_dir = 1'b0;
    run(1, 700, 80, 50);

    // Two payload beats with idle words between packets
    do_reset(2);
    use_dir = 1'b1;
    add_dir(8'hB8); add_dir(8'h12); add_dir(8'h30); add_dir(8'h00);
    add_dir(8'h00); add_dir(8'hB8); add_dir(8'h12); add_dir(8'h31);
    run(2, 10, 100, 0);
    run(2, 4, 0, 100);
    use_dir = 1'b0;
    run(2, 500, 75, 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
